// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode constants,
// FSM state type and the long-op classifier.
package alu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] OP_OP         = 7'b0110011;
  localparam logic [6:0] OP_OPW        = 7'b0111011;

  // {funct3, opcode} for the ops routed to the iterative divide unit
  typedef enum logic [9:0] {
    OPC_ADD   = 10'h033,
    OPC_DIV   = 10'h233,
    OPC_DIVU  = 10'h2B3,
    OPC_REM   = 10'h333,
    OPC_REMU  = 10'h3B3,
    OPC_DIVW  = 10'h23B,
    OPC_DIVUW = 10'h2BB,
    OPC_REMW  = 10'h33B,
    OPC_REMUW = 10'h3BB
  } opc_e;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LONG_WAIT = 1'b1
  } state_e;

  // DIV/DIVU/REM/REMU and their W forms; all MUL variants stay simple
  function automatic logic is_long(input logic [9:0] opcode, input logic [6:0] funct7);
    logic funct3_ok;
    logic major_ok;
    case (opcode[9:7])
      3'b100, 3'b101, 3'b110, 3'b111: funct3_ok = 1'b1;
      default:                        funct3_ok = 1'b0;
    endcase
    major_ok = (opcode[6:0] == OP_OP) || (opcode[6:0] == OP_OPW);
    return (funct7 == FUNCT7_MULDIV) && major_ok && funct3_ok;
  endfunction

endpackage

// File: rtl/alu_issue_wdog.sv
// Watchdog for the divide unit: counts wait cycles after long_start and
// flags expiry so the controller can abort a hung divide.
module alu_issue_wdog #(
  parameter int LONG_TIMEOUT = 80,
  parameter int CNT_W        = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // The controller registers its response, so fire one count early to land
  // the abort exactly LONG_TIMEOUT cycles after long_start.
  localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(LONG_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == FIRE_AT);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller between decode and the RV64 ALU: simple ops go
// through the registered ALU, divides go to an external iterative unit.
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int LONG_TIMEOUT = 80,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_opcode,
  input  logic [6:0] in_funct7,
  input  logic [4:0] in_rd,
  output logic       alu_go,
  output logic [9:0] alu_opcode,
  output logic [6:0] alu_funct7,
  output logic [4:0] alu_rd,
  output logic       long_start,
  output logic       long_abort,
  input  logic       long_done,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_sel,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  logic       s1_valid_q, s1_valid_d;
  logic       s1_long_q, s1_long_d;
  logic [9:0] s1_opcode_q, s1_opcode_d;
  logic [6:0] s1_funct7_q, s1_funct7_d;
  logic [4:0] s1_rd_q, s1_rd_d;
  logic       s2_valid_q, s2_valid_d;
  logic [4:0] s2_rd_q, s2_rd_d;
  logic       s2_sel_q, s2_sel_d;
  logic [4:0] long_rd_q, long_rd_d;
  logic       long_abort_q, long_abort_d;
  logic       err_q, err_d;

  logic accept_s;
  logic issue_long_s;
  logic issue_simple_s;
  logic wait_s;
  logic done_s;
  logic expire_s;
  logic timeout_s;

  assign in_ready       = !reset && !flush && (state_q == IDLE) && !(s1_valid_q && s1_long_q);
  assign accept_s       = in_valid && in_ready;
  assign issue_long_s   = s1_valid_q && s1_long_q;
  assign issue_simple_s = s1_valid_q && !s1_long_q;
  assign wait_s         = (state_q == LONG_WAIT);
  assign done_s         = wait_s && long_done;
  assign timeout_s      = expire_s && !done_s;

  alu_issue_wdog #(
    .LONG_TIMEOUT(LONG_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (issue_long_s),
    .en    (wait_s),
    .expire(expire_s)
  );

  // Next-state for the issue stage, writeback stage and sequencing FSM
  always_comb begin
    s1_valid_d   = 1'b0;
    s1_long_d    = s1_long_q;
    s1_opcode_d  = s1_opcode_q;
    s1_funct7_d  = s1_funct7_q;
    s1_rd_d      = s1_rd_q;
    s2_valid_d   = 1'b0;
    s2_rd_d      = s2_rd_q;
    s2_sel_d     = s2_sel_q;
    long_rd_d    = long_rd_q;
    state_d      = state_q;
    long_abort_d = 1'b0;
    err_d        = err_q;

    if (accept_s) begin
      s1_valid_d  = 1'b1;
      s1_long_d   = is_long(in_opcode, in_funct7);
      s1_opcode_d = in_opcode;
      s1_funct7_d = in_funct7;
      s1_rd_d     = in_rd;
    end else begin
      s1_valid_d  = 1'b0;
    end

    // A simple op can never be in S1 while a divide is waiting, so the
    // two writeback sources are mutually exclusive.
    if (issue_simple_s) begin
      s2_valid_d = 1'b1;
      s2_rd_d    = s1_rd_q;
      s2_sel_d   = 1'b0;
    end else if (done_s) begin
      s2_valid_d = 1'b1;
      s2_rd_d    = long_rd_q;
      s2_sel_d   = 1'b1;
    end else begin
      s2_valid_d = 1'b0;
    end

    if (issue_long_s) begin
      long_rd_d = s1_rd_q;
    end else begin
      long_rd_d = long_rd_q;
    end

    case (state_q)
      IDLE: begin
        if (issue_long_s) begin
          state_d = LONG_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      LONG_WAIT: begin
        if (long_done || expire_s) begin
          state_d = IDLE;
        end else begin
          state_d = LONG_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      s1_valid_d   = 1'b0;
      s2_valid_d   = 1'b0;
      state_d      = IDLE;
      long_abort_d = wait_s || issue_long_s;
    end else begin
      long_abort_d = timeout_s;
      err_d        = err_q || timeout_s;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_valid_q   <= 1'b0;
      s1_long_q    <= 1'b0;
      s1_opcode_q  <= 10'd0;
      s1_funct7_q  <= 7'd0;
      s1_rd_q      <= 5'd0;
      s2_valid_q   <= 1'b0;
      s2_rd_q      <= 5'd0;
      s2_sel_q     <= 1'b0;
      long_rd_q    <= 5'd0;
      long_abort_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_long_q    <= s1_long_d;
      s1_opcode_q  <= s1_opcode_d;
      s1_funct7_q  <= s1_funct7_d;
      s1_rd_q      <= s1_rd_d;
      s2_valid_q   <= s2_valid_d;
      s2_rd_q      <= s2_rd_d;
      s2_sel_q     <= s2_sel_d;
      long_rd_q    <= long_rd_d;
      long_abort_q <= long_abort_d;
      err_q        <= err_d;
    end
  end

  assign alu_go     = issue_simple_s;
  assign alu_opcode = s1_opcode_q;
  assign alu_funct7 = s1_funct7_q;
  assign alu_rd     = s1_rd_q;
  assign long_start = issue_long_s;
  assign long_abort = long_abort_q;
  assign wb_valid   = s2_valid_q && (s2_rd_q != 5'd0);
  assign wb_rd      = s2_rd_q;
  assign wb_sel     = s2_sel_q;
  assign busy       = s1_valid_q || s2_valid_q || wait_s;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed timing scenarios plus a
// randomized run against a schedule-based reference model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, long_done;
  logic [9:0] in_opcode;
  logic [6:0] in_funct7;
  logic [4:0] in_rd;
  logic       in_ready, alu_go, long_start, long_abort, wb_valid, wb_sel, busy, err;
  logic [9:0] alu_opcode;
  logic [6:0] alu_funct7;
  logic [4:0] alu_rd, wb_rd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.LONG_TIMEOUT(80), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct7(in_funct7), .in_rd(in_rd),
    .alu_go(alu_go), .alu_opcode(alu_opcode), .alu_funct7(alu_funct7), .alu_rd(alu_rd),
    .long_start(long_start), .long_abort(long_abort), .long_done(long_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .busy(busy), .err(err)
  );

  // {ready, go, start, abort, wb_valid, wb_sel, wb_rd, busy, err}
  function automatic logic [12:0] pack(input logic rdy, input logic go, input logic st,
                                       input logic ab, input logic wv, input logic sel,
                                       input logic [4:0] rd, input logic bz, input logic er);
    return {rdy, go, st, ab, wv, sel, rd, bz, er};
  endfunction

  // wb_rd/wb_sel are only meaningful while wb_valid is high
  function automatic logic [12:0] snap();
    return {in_ready, alu_go, long_start, long_abort, wb_valid, wb_valid & wb_sel,
            wb_valid ? wb_rd : 5'd0, busy, err};
  endfunction

  function automatic bit spec_long(input logic [9:0] op, input logic [6:0] f7);
    return (f7 == 7'd1) && (op[6:0] == 7'h33 || op[6:0] == 7'h3B) && (op[9:7] >= 3'd4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    flush     = 1'b0;
    long_done = 1'b0;
    in_opcode = 10'd0;
    in_funct7 = 7'd0;
    in_rd     = 5'd0;
  endtask

  task automatic drive_op(input logic [9:0] op, input logic [6:0] f7, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct7 = f7;
    in_rd     = rd;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] want;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    want = pack(0, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    total++; if (snap() !== want) $display("FAIL reset_state got %b want %b", snap(), want); else passed++;
    total++; if ({alu_opcode, alu_funct7, alu_rd, wb_rd, wb_sel} !== 28'd0)
      $display("FAIL reset_fields got %h want 0", {alu_opcode, alu_funct7, alu_rd, wb_rd, wb_sel}); else passed++;
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_simple();
    logic [12:0] want;
    tick(); drive_op(10'h033, 7'd0, 5'd5); #1;
    want = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    total++; if (snap() !== want) $display("FAIL simple_accept got %b want %b", snap(), want); else passed++;
    tick(); idle_inputs(); #1;
    want = pack(1, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    total++; if (snap() !== want) $display("FAIL simple_go got %b want %b", snap(), want); else passed++;
    total++; if ({alu_opcode, alu_funct7, alu_rd} !== {10'h033, 7'd0, 5'd5})
      $display("FAIL simple_fields got %h want %h", {alu_opcode, alu_funct7, alu_rd}, {10'h033, 7'd0, 5'd5}); else passed++;
    tick(); #1;
    want = pack(1, 0, 0, 0, 1, 0, 5'd5, 1, 0);
    total++; if (snap() !== want) $display("FAIL simple_wb got %b want %b", snap(), want); else passed++;
    tick(); #1;
    want = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    total++; if (snap() !== want) $display("FAIL simple_idle got %b want %b", snap(), want); else passed++;
  endtask

  // MUL, MULW and SUB back to back: all simple, one per cycle
  task automatic test_back_to_back();
    logic [12:0] want;
    logic [21:0] ops [3];
    ops[0] = {10'h033, 7'd1,    5'd1};
    ops[1] = {10'h03B, 7'd1,    5'd2};
    ops[2] = {10'h033, 7'h20,   5'd3};
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 3) drive_op(ops[i][21:12], ops[i][11:5], ops[i][4:0]); else idle_inputs();
      #1;
      want = pack(1, (i >= 1 && i <= 3), 0, 0, (i >= 2 && i <= 4), 0,
                  (i >= 2 && i <= 4) ? 5'(i - 1) : 5'd0, (i >= 1 && i <= 4), 0);
      total++; if (snap() !== want) $display("FAIL b2b_c%0d got %b want %b", i, snap(), want); else passed++;
      if (i >= 1 && i <= 3) begin
        total++; if ({alu_opcode, alu_funct7, alu_rd} !== ops[i-1])
          $display("FAIL b2b_fields_c%0d got %h want %h", i, {alu_opcode, alu_funct7, alu_rd}, ops[i-1]); else passed++;
      end
    end
  endtask

  task automatic test_div();
    logic [12:0] want;
    tick(); drive_op(10'h233, 7'd1, 5'd7); #1;
    want = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    total++; if (snap() !== want) $display("FAIL div_accept got %b want %b", snap(), want); else passed++;
    // long_done in the long_start cycle must be ignored; offered op must stall
    tick(); drive_op(10'h033, 7'd0, 5'd11); long_done = 1'b1; #1;
    want = pack(0, 0, 1, 0, 0, 0, 5'd0, 1, 0);
    total++; if (snap() !== want) $display("FAIL div_start got %b want %b", snap(), want); else passed++;
    for (int c = 2; c <= 17; c++) begin
      tick(); idle_inputs(); if (c == 2) drive_op(10'h033, 7'd0, 5'd11); #1;
      want = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
      total++; if (snap() !== want) $display("FAIL div_wait_c%0d got %b want %b", c, snap(), want); else passed++;
    end
    tick(); idle_inputs(); long_done = 1'b1; #1;
    want = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    total++; if (snap() !== want) $display("FAIL div_done got %b want %b", snap(), want); else passed++;
    tick(); idle_inputs(); #1;
    want = pack(1, 0, 0, 0, 1, 1, 5'd7, 1, 0);
    total++; if (snap() !== want) $display("FAIL div_wb got %b want %b", snap(), want); else passed++;
    tick(); #1;
    want = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    total++; if (snap() !== want) $display("FAIL div_idle got %b want %b", snap(), want); else passed++;
  endtask

  task automatic test_simple_then_long();
    logic [12:0] want [7];
    want[0] = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    want[1] = pack(1, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    want[2] = pack(0, 0, 1, 0, 1, 0, 5'd4, 1, 0);
    want[3] = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    want[4] = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    want[5] = pack(1, 0, 0, 0, 1, 1, 5'd9, 1, 0);
    want[6] = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      tick(); idle_inputs();
      if (c == 0) drive_op(10'h033, 7'd0, 5'd4);
      if (c == 1) drive_op(10'h23B, 7'd1, 5'd9);
      if (c == 4) long_done = 1'b1;
      #1;
      total++; if (snap() !== want[c]) $display("FAIL mix_c%0d got %b want %b", c, snap(), want[c]); else passed++;
    end
  endtask

  task automatic test_watchdog();
    logic [12:0] want;
    tick(); drive_op(10'h3B3, 7'd1, 5'd12); #1;
    tick(); idle_inputs(); #1;
    want = pack(0, 0, 1, 0, 0, 0, 5'd0, 1, 0);
    total++; if (snap() !== want) $display("FAIL wd_start got %b want %b", snap(), want); else passed++;
    for (int k = 1; k < 80; k++) begin
      tick(); #1;
      want = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
      total++; if (snap() !== want) $display("FAIL wd_wait_k%0d got %b want %b", k, snap(), want); else passed++;
    end
    tick(); drive_op(10'h033, 7'd0, 5'd6); #1;
    want = pack(1, 0, 0, 1, 0, 0, 5'd0, 0, 1);
    total++; if (snap() !== want) $display("FAIL wd_expire got %b want %b", snap(), want); else passed++;
    tick(); idle_inputs(); #1;
    want = pack(1, 1, 0, 0, 0, 0, 5'd0, 1, 1);
    total++; if (snap() !== want) $display("FAIL wd_after_go got %b want %b", snap(), want); else passed++;
    tick(); #1;
    want = pack(1, 0, 0, 0, 1, 0, 5'd6, 1, 1);
    total++; if (snap() !== want) $display("FAIL wd_after_wb got %b want %b", snap(), want); else passed++;
    tick(); #1;
    want = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 1);
    total++; if (snap() !== want) $display("FAIL wd_sticky got %b want %b", snap(), want); else passed++;
  endtask

  task automatic test_flush();
    logic [12:0] want [10];
    do_reset();
    // flush in LONG_WAIT, stray long_done afterwards, then an rd=0 op
    want[0] = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    want[1] = pack(0, 0, 1, 0, 0, 0, 5'd0, 1, 0);
    want[2] = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    want[3] = pack(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    want[4] = pack(1, 0, 0, 1, 0, 0, 5'd0, 0, 0);
    want[5] = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    want[6] = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    want[7] = pack(1, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    want[8] = pack(1, 0, 0, 0, 0, 0, 5'd0, 1, 0);
    want[9] = pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      tick(); idle_inputs();
      if (c == 0) drive_op(10'h233, 7'd1, 5'd8);
      if (c == 3) begin flush = 1'b1; drive_op(10'h033, 7'd0, 5'd13); end
      if (c == 5) long_done = 1'b1;
      if (c == 6) drive_op(10'h033, 7'd0, 5'd0);
      #1;
      total++; if (snap() !== want[c]) $display("FAIL flush_wait_c%0d got %b want %b", c, snap(), want[c]); else passed++;
    end
    // flush while the divide sits in S1 (long_start cycle)
    for (int c = 0; c < 4; c++) begin
      tick(); idle_inputs();
      if (c == 0) drive_op(10'h2B3, 7'd1, 5'd10);
      if (c == 1) flush = 1'b1;
      #1;
      want[c] = (c == 0) ? pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0) :
                (c == 1) ? pack(0, 0, 1, 0, 0, 0, 5'd0, 1, 0) :
                (c == 2) ? pack(1, 0, 0, 1, 0, 0, 5'd0, 0, 0) :
                           pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
      total++; if (snap() !== want[c]) $display("FAIL flush_s1_c%0d got %b want %b", c, snap(), want[c]); else passed++;
    end
    // flush overrides a same-cycle handshake and kills a pending writeback
    for (int c = 0; c < 4; c++) begin
      tick(); idle_inputs();
      if (c == 0) drive_op(10'h033, 7'd0, 5'd14);
      if (c == 1) begin flush = 1'b1; drive_op(10'h033, 7'd0, 5'd15); end
      #1;
      want[c] = (c == 0) ? pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0) :
                (c == 1) ? pack(0, 1, 0, 0, 0, 0, 5'd0, 1, 0) :
                           pack(1, 0, 0, 0, 0, 0, 5'd0, 0, 0);
      total++; if (snap() !== want[c]) $display("FAIL flush_hs_c%0d got %b want %b", c, snap(), want[c]); else passed++;
    end
  endtask

  // Reference model: each accepted op schedules its observable events by
  // the timing rules (simple: go at +1, wb at +2; long: start at +1, wb the
  // cycle after its long_done, no accepts until then).
  task automatic test_random();
    localparam int NC = 400;
    bit          exp_go    [NC+16];
    bit [21:0]   exp_alu   [NC+16];
    bit          exp_start [NC+16];
    bit          exp_wbv   [NC+16];
    bit [5:0]    exp_wb    [NC+16];
    bit          exp_busy  [NC+16];
    int          ready_at  = 0;
    int          start_cyc = -100;
    int          done_cyc  = -100;
    bit          exp_ready;
    logic [12:0] want;
    logic [9:0]  op;
    logic [6:0]  f7;
    logic [4:0]  rd;
    do_reset();
    for (int c = 0; c < NC; c++) begin
      tick(); idle_inputs();
      if (c == done_cyc) long_done = 1'b1;
      else if (!(c > start_cyc && c <= done_cyc) && $urandom_range(7) == 0) long_done = 1'b1;
      if ($urandom_range(3) != 0) begin
        case ($urandom_range(12))
          0:       begin op = 10'h033; f7 = 7'h00; end
          1:       begin op = 10'h033; f7 = 7'h20; end
          2:       begin op = 10'h033; f7 = 7'h01; end
          3:       begin op = 10'h1B3; f7 = 7'h01; end
          4:       begin op = 10'h233; f7 = 7'h01; end
          5:       begin op = 10'h2B3; f7 = 7'h01; end
          6:       begin op = 10'h333; f7 = 7'h01; end
          7:       begin op = 10'h3B3; f7 = 7'h01; end
          8:       begin op = 10'h23B; f7 = 7'h01; end
          9:       begin op = 10'h3BB; f7 = 7'h01; end
          10:      begin op = 10'h03B; f7 = 7'h01; end
          11:      begin op = 10'h213; f7 = 7'h01; end
          default: begin op = 10'h2B3; f7 = 7'h20; end
        endcase
        rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
        drive_op(op, f7, rd);
      end
      exp_ready = (c >= ready_at);
      #1;
      want = pack(exp_ready, exp_go[c], exp_start[c], 0, exp_wbv[c], exp_wb[c][5],
                  exp_wbv[c] ? exp_wb[c][4:0] : 5'd0, exp_busy[c], 0);
      total++; if (snap() !== want) $display("FAIL rand_c%0d got %b want %b", c, snap(), want); else passed++;
      if (exp_go[c]) begin
        total++; if ({alu_opcode, alu_funct7, alu_rd} !== exp_alu[c])
          $display("FAIL rand_fields_c%0d got %h want %h", c, {alu_opcode, alu_funct7, alu_rd}, exp_alu[c]); else passed++;
      end
      if (in_valid && exp_ready) begin
        if (spec_long(in_opcode, in_funct7)) begin
          start_cyc = c + 1;
          done_cyc  = start_cyc + int'($urandom_range(6, 1));
          ready_at  = done_cyc + 1;
          exp_start[start_cyc] = 1'b1;
          for (int k = start_cyc; k <= done_cyc + 1; k++) exp_busy[k] = 1'b1;
          if (in_rd != 5'd0) begin
            exp_wbv[done_cyc + 1] = 1'b1;
            exp_wb[done_cyc + 1]  = {1'b1, in_rd};
          end
        end else begin
          exp_go[c + 1]   = 1'b1;
          exp_alu[c + 1]  = {in_opcode, in_funct7, in_rd};
          exp_busy[c + 1] = 1'b1;
          exp_busy[c + 2] = 1'b1;
          if (in_rd != 5'd0) begin
            exp_wbv[c + 2] = 1'b1;
            exp_wb[c + 2]  = {1'b0, in_rd};
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_simple();
    test_back_to_back();
    test_div();
    test_simple_then_long();
    test_watchdog();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
